// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Bit-serial framed transmitter. A word accepted on the valid/ready
//   handshake is sent as: start bit (0), DATA_W data bits LSB first,
//   optional parity bit, stop bit (1). Each line bit is held for
//   CLKS_PER_BIT clocks. The line idles high.
//
// Ports
//   clk              clock, all state changes on posedge
//   rst              synchronous reset, active-low
//   i_data           word to transmit
//   i_valid          i_data valid; accepted only while idle
//   o_ready          high only in IDLE
//   o_serial         serial line output (idle 1)
//   o_busy           frame in progress
//   o_done           one-cycle pulse in the last cycle of STOP
//   o_current_state  registered state code
//   o_next_state     combinational next state code
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_serial,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_current_state,
    output logic [2:0]        o_next_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } state_t;

    state_t            state, n_state;
    logic [CNT_W-1:0]  cnt, n_cnt;
    logic [IDX_W-1:0]  idx, n_idx;
    logic [DATA_W-1:0] shift, n_shift;
    logic              par, n_par;
    logic              n_serial, n_done;
    logic              bit_end;

    assign bit_end = (cnt == CNT_LAST);

    // Next-state and next-datapath values. The outputs are registered from
    // these same values, so they always match a decode of the registered
    // state without any extra cycle of latency.
    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_idx   = idx;
        n_shift = shift;
        n_par   = par;

        case (state)
            IDLE: begin
                if (i_valid) begin
                    n_state = START;
                    n_cnt   = '0;
                    n_idx   = '0;
                    n_shift = i_data;
                    n_par   = (^i_data) ^ (PARITY_ODD != 0);
                end
            end
            START: begin
                n_cnt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) n_state = DATA;
            end
            DATA: begin
                n_cnt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    n_shift = shift >> 1;
                    if (idx == IDX_LAST) begin
                        n_idx   = '0;
                        n_state = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        n_idx = idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                n_cnt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) n_state = STOP;
            end
            STOP: begin
                n_cnt = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) n_state = IDLE;
            end
            default: begin
                n_state = IDLE;
                n_cnt   = '0;
                n_idx   = '0;
            end
        endcase

        if (!rst) begin
            n_state = IDLE;
            n_cnt   = '0;
            n_idx   = '0;
            n_shift = '0;
            n_par   = 1'b0;
        end

        case (n_state)
            START:   n_serial = 1'b0;
            DATA:    n_serial = n_shift[0];
            PARITY:  n_serial = n_par;
            default: n_serial = 1'b1;
        endcase
        n_done = (n_state == STOP) && (n_cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            par      <= 1'b0;
            o_serial <= 1'b1;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= n_state;
            cnt      <= n_cnt;
            idx      <= n_idx;
            shift    <= n_shift;
            par      <= n_par;
            o_serial <= n_serial;
            o_ready  <= (n_state == IDLE);
            o_busy   <= (n_state != IDLE);
            o_done   <= n_done;
        end
    end

    assign o_current_state = state;
    assign o_next_state    = n_state;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx. Three instances share one stimulus stream:
//   d0: defaults (8 bits, 4 clocks/bit, even parity)
//   d1: odd parity
//   d2: no parity, 1 clock/bit
// Each instance has a reference model that expands an accepted word into
// the full list of expected per-cycle (line, state, done) values.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_valid;

    logic       ready [3];
    logic       ser   [3];
    logic       busy  [3];
    logic       done  [3];
    logic [2:0] cst   [3];
    logic [2:0] nst   [3];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_d0 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(ready[0]), .o_serial(ser[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_current_state(cst[0]), .o_next_state(nst[0]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_d1 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(ready[1]), .o_serial(ser[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_current_state(cst[1]), .o_next_state(nst[1]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_d2 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(ready[2]), .o_serial(ser[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_current_state(cst[2]), .o_next_state(nst[2]));

    typedef struct packed {
        logic       ser;
        logic [2:0] st;
        logic       done;
    } exp_t;

    int   cpb  [3] = '{4, 4, 1};
    int   pen  [3] = '{1, 1, 0};
    int   podd [3] = '{0, 1, 0};
    exp_t mq   [3][$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected frame: start, 8 data bits LSB first, optional parity, stop.
    function automatic void push_frame(input int m, input logic [7:0] d);
        int   nbits;
        exp_t e;
        nbits = 10 + pen[m];
        for (int b = 0; b < nbits; b++) begin
            if (b == 0) begin
                e.ser = 1'b0; e.st = 3'd1;
            end else if (b <= 8) begin
                e.ser = d[b-1]; e.st = 3'd2;
            end else if (pen[m] != 0 && b == 9) begin
                e.ser = (^d) ^ podd[m][0]; e.st = 3'd3;
            end else begin
                e.ser = 1'b1; e.st = 3'd4;
            end
            for (int c = 0; c < cpb[m]; c++) begin
                e.done = (b == nbits - 1) && (c == cpb[m] - 1);
                mq[m].push_back(e);
            end
        end
    endfunction

    // One clock: check combinational next state, advance models at the edge,
    // then check registered outputs on the falling edge.
    task automatic step();
        exp_t e;
        logic [2:0] ens;
        #1;
        for (int m = 0; m < 3; m++) begin
            if (!rst) ens = 3'd0;
            else if (mq[m].size() == 0) ens = i_valid ? 3'd1 : 3'd0;
            else if (mq[m].size() > 1) ens = mq[m][1].st;
            else ens = 3'd0;
            check($sformatf("d%0d_next_state", m), 32'(nst[m]), 32'(ens));
        end
        @(posedge clk);
        for (int m = 0; m < 3; m++) begin
            if (!rst) mq[m].delete();
            else if (mq[m].size() == 0) begin
                if (i_valid) push_frame(m, i_data);
            end else begin
                void'(mq[m].pop_front());
            end
        end
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            if (mq[m].size() > 0) e = mq[m][0];
            else e = '{ser: 1'b1, st: 3'd0, done: 1'b0};
            check($sformatf("d%0d_serial", m), 32'(ser[m]), 32'(e.ser));
            check($sformatf("d%0d_state", m), 32'(cst[m]), 32'(e.st));
            check($sformatf("d%0d_done", m), 32'(done[m]), 32'(e.done));
            check($sformatf("d%0d_ready", m), 32'(ready[m]), 32'(mq[m].size() == 0));
            check($sformatf("d%0d_busy", m), 32'(busy[m]), 32'(mq[m].size() != 0));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mq[0].size() != 0 || mq[1].size() != 0 || mq[2].size() != 0) && n < 200) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        i_valid = 1'b1;
        i_data  = d;
        step();
        i_valid = 1'b0;
        i_data  = 8'h00;
        wait_idle();
        step();
    endtask

    initial begin
        rst     = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hFF;
        @(negedge clk);
        step();
        step();
        rst     = 1'b1;
        i_valid = 1'b0;
        step();

        send(8'hA5);
        send(8'h07);

        // Held valid with data change mid-frame.
        i_valid = 1'b1;
        i_data  = 8'h3C;
        for (int i = 0; i < 10; i++) step();
        i_data = 8'hC3;
        for (int i = 0; i < 60; i++) step();
        i_valid = 1'b0;
        wait_idle();
        step();

        // Reset during data bit 3 of 0x5A on the 4-clock instances.
        i_valid = 1'b1;
        i_data  = 8'h5A;
        step();
        i_valid = 1'b0;
        for (int i = 0; i < 17; i++) step();
        rst     = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hEE;
        step();
        rst     = 1'b1;
        i_valid = 1'b0;
        step();
        send(8'h81);
        send(8'h01);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = 8'($urandom);
            rst     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst     = 1'b1;
        i_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
